sha256_msg_feeder: RTL and testbench

//  Initiator side of the sha256_core_v2 block interface. Accepts a byte stream per message and builds 512-bit blocks.

---
 rtl/sha256_msg_feeder_pkg.sv | 23 ++
 rtl/sha256_msg_feeder_if.sv | 45 ++++
 rtl/sha256_msg_feeder_pad_fill.sv | 33 +++
 rtl/sha256_msg_feeder.sv | 180 ++++++++++++++++++
 tb/tb_sha256_msg_feeder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_msg_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sha256_pkg
//  Description : Shared state encoding and block-format constants for the
//                SHA-256 message feeder.
//  Revision    : 1.0  initial release
// ============================================================================
package sha256_pkg;

    localparam int        BLK_BYTES = 64;
    localparam int        LEN_OFF   = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        FILL      = 3'd0,
        PAD       = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        RELEASE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sha256_msg_feeder_if.sv
`default_nettype none
// ============================================================================
//  Interface   : sha256_msg_feeder_if
//  Description : Host byte stream, core block handshake and digest output.
//                SHA256_FEEDER_ABORT_EN adds the abort input.
//  Revision    : 1.0  initial release
// ============================================================================
interface sha256_msg_feeder_if;

    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_last;
    logic         s_nobyte;
    logic         s_ready;
    logic [511:0] core_block;
    logic         core_start;
    logic         core_first;
    logic         core_ready;
    logic [255:0] core_hash;
    logic [255:0] digest;
    logic         digest_valid;
`ifdef SHA256_FEEDER_ABORT_EN
    logic         abort;
`endif

    // Feeder view
    modport master (
`ifdef SHA256_FEEDER_ABORT_EN
        input  abort,
`endif
        input  s_valid, s_data, s_last, s_nobyte, core_ready, core_hash,
        output s_ready, core_block, core_start, core_first, digest, digest_valid
    );

    // Host/core view
    modport slave (
`ifdef SHA256_FEEDER_ABORT_EN
        output abort,
`endif
        output s_valid, s_data, s_last, s_nobyte, core_ready, core_hash,
        input  s_ready, core_block, core_start, core_first, digest, digest_valid
    );

endinterface
`default_nettype wire

// File: rtl/sha256_msg_feeder_pad_fill.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pad_fill
//  Description : Combinational block formatter: keeps bytes below i_p, puts
//                the 0x80 marker at i_p, zero-fills, optionally adds length.
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_pad_fill
    import sha256_pkg::*;
(
    input  wire logic [511:0] i_blk,
    input  wire logic [5:0]   i_p,
    input  wire logic         i_mark,
    input  wire logic [63:0]  i_len,
    input  wire logic         i_len_en,
    output logic      [511:0] o_blk
);

    always_comb begin
        o_blk = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if (i < int'(i_p))
                o_blk[511-8*i -: 8] = i_blk[511-8*i -: 8];
            else if ((i == int'(i_p)) && i_mark)
                o_blk[511-8*i -: 8] = PAD_BYTE;
            // Length field is big-endian in the last eight bytes
            if (i_len_en && (i >= LEN_OFF))
                o_blk[511-8*i -: 8] = i_len[8*(63-i)+7 -: 8];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sha256_msg_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_feeder
//  Description : Packs a host byte stream into padded 512-bit blocks and
//                drives the sha256_core_v2 handshake; captures the digest.
//                SHA256_FEEDER_ABORT_EN enables message abort.
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_msg_feeder
    import sha256_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  wire logic            clk,
    input  wire logic            rst,
    sha256_msg_feeder_if.master  bus
);

    state_t             r_state, w_next;
    logic [511:0]       r_buf;
    logic [5:0]         r_idx;
    logic [5:0]         r_p;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_fin, r_need_len, r_pad_pend, r_first, r_abort_pend;
    logic [255:0]       r_digest;
    logic               r_dvalid;

    logic               w_abort, w_accept, w_term, w_store, w_short;
    logic               w_s_ready, w_start;
    logic [8:0]         w_wr_hi;
    logic [5:0]         w_pf_p;
    logic               w_pf_mark, w_pf_len_en;
    logic [63:0]        w_len;
    logic [511:0]       w_pf_blk;

`ifdef SHA256_FEEDER_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept = bus.s_valid && (r_state == FILL);
    assign w_term   = w_accept && bus.s_last && bus.s_nobyte;
    assign w_store  = w_accept && !w_term;
    assign w_wr_hi  = 9'd511 - {r_idx, 3'b000};
    assign w_len    = 64'({r_cnt, 3'b000});
    assign w_short  = (r_p <= 6'(LEN_OFF - 1));

    // The formatter serves both the marker pass and the length-only block
    assign w_pf_mark   = (r_state == PAD);
    assign w_pf_p      = (r_state == PAD) ? r_p : 6'd0;
    assign w_pf_len_en = (r_state == PAD) ? w_short : 1'b1;

    sha256_pad_fill u_pad_fill (
        .i_blk    (r_buf),
        .i_p      (w_pf_p),
        .i_mark   (w_pf_mark),
        .i_len    (w_len),
        .i_len_en (w_pf_len_en),
        .o_blk    (w_pf_blk)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_s_ready = 1'b0;
        w_start   = 1'b0;
        case (r_state)
            FILL: begin
                w_s_ready = 1'b1;
                if (w_abort)                    w_next = FILL;
                else if (w_term)                w_next = PAD;
                else if (w_store && r_idx == 6'd63) w_next = ISSUE;
                else if (w_store && bus.s_last) w_next = PAD;
            end
            PAD:       w_next = w_abort ? FILL : ISSUE;
            ISSUE: begin
                w_start = 1'b1;
                // A stale high ready from the last block is not acceptance
                if (!bus.core_ready) w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                w_start = 1'b1;
                if (bus.core_ready) w_next = RELEASE;
            end
            RELEASE: begin
                if (r_abort_pend || r_fin) w_next = FILL;
                else if (r_need_len)       w_next = ISSUE;
                else if (r_pad_pend)       w_next = PAD;
                else                       w_next = FILL;
            end
            default:   w_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf        <= '0;
            r_idx        <= '0;
            r_p          <= '0;
            r_cnt        <= '0;
            r_fin        <= 1'b0;
            r_need_len   <= 1'b0;
            r_pad_pend   <= 1'b0;
            r_first      <= 1'b1;
            r_abort_pend <= 1'b0;
            r_digest     <= '0;
            r_dvalid     <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            case (r_state)
                FILL, PAD: begin
                    if (w_abort) begin
                        r_buf      <= '0;
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        r_first    <= 1'b1;
                        r_pad_pend <= 1'b0;
                    end else if (r_state == PAD) begin
                        r_buf      <= w_pf_blk;
                        r_fin      <= w_short;
                        r_need_len <= !w_short;
                    end else if (w_term) begin
                        r_p <= r_idx;
                    end else if (w_store) begin
                        r_buf[w_wr_hi -: 8] <= bus.s_data;
                        r_idx <= r_idx + 6'd1;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_idx == 6'd63) r_pad_pend <= bus.s_last;
                        else if (bus.s_last) r_p <= r_idx + 6'd1;
                    end
                end
                ISSUE, WAIT_DONE: begin
                    if (w_abort) r_abort_pend <= 1'b1;
                end
                RELEASE: begin
                    r_first <= 1'b0;
                    if (r_abort_pend) begin
                        r_buf        <= '0;
                        r_cnt        <= '0;
                        r_idx        <= '0;
                        r_fin        <= 1'b0;
                        r_need_len   <= 1'b0;
                        r_pad_pend   <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_first      <= 1'b1;
                    end else if (r_fin) begin
                        r_digest <= bus.core_hash;
                        r_dvalid <= 1'b1;
                        r_first  <= 1'b1;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_fin    <= 1'b0;
                    end else if (r_need_len) begin
                        r_buf      <= w_pf_blk;
                        r_fin      <= 1'b1;
                        r_need_len <= 1'b0;
                    end else if (r_pad_pend) begin
                        r_p        <= 6'd0;
                        r_pad_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready      = w_s_ready;
    assign bus.core_start   = w_start;
    assign bus.core_block   = r_buf;
    assign bus.core_first   = r_first;
    assign bus.digest       = r_digest;
    assign bus.digest_valid = r_dvalid;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_msg_feeder
//  Description : Randomized bench for sha256_msg_feeder with a behavioural
//                SHA-256 core and a byte-level padding reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha256_msg_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_msg_feeder_if bus();

    sha256_msg_feeder #(.CNT_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SHA256_FEEDER_ABORT_EN
    initial bus.abort = 1'b0;
`endif

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    int n_vec = 0;
    int n_err = 0;

    logic [511:0] q_blk [$];
    bit           q_first [$];
    logic [255:0] q_dig [$];
    logic [255:0] last_dig = '0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-7] + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96]  + e, hin[95:64]   + f, hin[63:32]   + g, hin[31:0]    + h};
    endfunction

    // Reference: FIPS 180-4 padding on a byte list, split into blocks
    task automatic push_expected(input logic [7:0] msg [$]);
        logic [7:0]   p [$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        logic [255:0] hs;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bitlen = 64'(msg.size()) * 64'd8;
        for (int k = 0; k < 8; k++) p.push_back(bitlen[63-8*k -: 8]);
        hs = IV;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi + j];
            q_blk.push_back(blk);
            q_first.push_back(bi == 0);
            hs = compress(hs, blk);
        end
        q_dig.push_back(hs);
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last, input bit nob);
        bit rdy = 1'b0;
        bus.s_valid  = 1'b1;
        bus.s_data   = d;
        bus.s_last   = last;
        bus.s_nobyte = nob;
        for (int n = 0; n < 2000; n++) begin
            rdy = bus.s_ready;
            @(posedge clk); #1;
            if (rdy) break;
        end
        if (!rdy) chk("s_ready_timeout", 512'(rdy), 512'd1);
        bus.s_valid  = 1'b0;
        bus.s_last   = 1'b0;
        bus.s_nobyte = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg [$], input bit defer);
        push_expected(msg);
        for (int i = 0; i < msg.size(); i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            send_beat(msg[i], (i == msg.size() - 1) && !defer, 1'b0);
        end
        if (defer || msg.size() == 0) send_beat(8'($urandom), 1'b1, 1'b1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 3000; n++) begin
            if (q_dig.size() == 0 && q_blk.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("pending_digests", 512'(q_dig.size()), 512'd0);
        chk("pending_blocks", 512'(q_blk.size()), 512'd0);
    endtask

    function automatic void str_msg(input string s, output logic [7:0] m [$]);
        m = {};
        for (int i = 0; i < s.len(); i++) m.push_back(8'(s[i]));
    endfunction

    // Behavioural core: stale ready, random accept and compute latency
    initial begin : core_model
        int phase = 0, dly = 0;
        logic [511:0] held;
        logic [255:0] hs = '0;
        bus.core_ready = 1'b1;
        bus.core_hash  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                phase = 0;
                bus.core_ready = 1'b1;
            end else begin
                if (bus.core_start) chk("s_ready_while_start", 512'(bus.s_ready), 512'd0);
                if (bus.digest_valid) begin
                    if (q_dig.size() == 0) chk("spurious_digest", 512'(bus.digest_valid), 512'd0);
                    else chk("digest", 512'(bus.digest), 512'(q_dig.pop_front()));
                    last_dig = bus.digest;
                end
                case (phase)
                    0: if (bus.core_start) begin dly = $urandom_range(0, 3); phase = 1; end
                    1: begin
                        chk("start_held_stale_ready", 512'(bus.core_start), 512'd1);
                        if (dly > 0) dly--;
                        else begin
                            held = bus.core_block;
                            if (q_blk.size() == 0) chk("unexpected_block", 512'(bus.core_start), 512'd0);
                            else begin
                                chk("block", held, q_blk.pop_front());
                                chk("first", 512'(bus.core_first), 512'(q_first.pop_front()));
                            end
                            hs = compress(bus.core_first ? IV : hs, held);
                            bus.core_ready = 1'b0;
                            dly = $urandom_range(1, 6);
                            phase = 2;
                        end
                    end
                    2: begin
                        chk("block_stable", bus.core_block, held);
                        chk("start_held_busy", 512'(bus.core_start), 512'd1);
                        if (dly > 0) dly--;
                        else begin
                            bus.core_ready = 1'b1;
                            bus.core_hash  = hs;
                            phase = 3;
                        end
                    end
                    default: begin
                        chk("start_release", 512'(bus.core_start), 512'd0);
                        phase = 0;
                    end
                endcase
            end
        end
    end

    initial begin : main
        logic [7:0] m [$];
        bit ok;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.s_nobyte = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 512'(bus.s_ready), 512'd1);
        chk("rst_core_start", 512'(bus.core_start), 512'd0);
        chk("rst_core_first", 512'(bus.core_first), 512'd1);
        chk("rst_core_block", bus.core_block, 512'd0);
        chk("rst_digest", 512'(bus.digest), 512'd0);
        chk("rst_digest_valid", 512'(bus.digest_valid), 512'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        str_msg("abc", m);
        send_msg(m, 1'b0);
        wait_drain();
        chk("abc_digest", 512'(last_dig),
            512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

        m = {};
        send_msg(m, 1'b1);
        wait_drain();
        chk("empty_digest", 512'(last_dig),
            512'(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855));

        str_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", m);
        send_msg(m, 1'b0);
        wait_drain();
        chk("abc56_digest", 512'(last_dig),
            512'(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1));

        m = {};
        repeat (64) m.push_back(8'h61);
        send_msg(m, 1'b0);
        wait_drain();
        m = {};
        repeat (55) m.push_back(8'h61);
        send_msg(m, 1'b0);
        wait_drain();

        // Reset while the core is busy on a block
        str_msg("abc", m);
        send_msg(m, 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (bus.core_start && !bus.core_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("reach_wait_done", 512'(ok), 512'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_core_start", 512'(bus.core_start), 512'd0);
        chk("midrst_s_ready", 512'(bus.s_ready), 512'd1);
        chk("midrst_digest_valid", 512'(bus.digest_valid), 512'd0);
        q_blk = {}; q_first = {}; q_dig = {};
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_msg(m, 1'b0);
        wait_drain();
        chk("post_rst_abc_digest", 512'(last_dig),
            512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

        // Length boundaries followed by fully random messages
        for (int t = 0; t < 34; t++) begin
            int len;
            case (t)
                0: len = 0;    1: len = 1;    2: len = 55;   3: len = 56;
                4: len = 63;   5: len = 64;   6: len = 65;   7: len = 119;
                8: len = 120;  9: len = 128;
                default: len = $urandom_range(0, 150);
            endcase
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            send_msg(m, $urandom_range(0, 2) == 0);
            wait_drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
